// File: rtl/teller_call_scheduler.sv
// Bank ticket dispenser and teller call scheduler: issues queue numbers,
// latches teller call buttons and announces one call at a time, round-robin.
//
// state    | meaning
// IDLE     | waiting for a pending teller and a waiting customer
// ANNOUNCE | call offered to the announcer, held until ann_ready
// GAP_WAIT | quiet period of GAP cycles after each announced call
module teller_call_scheduler #(
    parameter int N_TEL = 4,
    parameter int CNT_W = 8,
    parameter int GAP   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bank_open,
    input  logic [N_TEL-1:0]           teller_open,
    input  logic [N_TEL-1:0]           call_req,
    input  logic                       take_num,
    input  logic                       ann_ready,
    output logic [CNT_W-1:0]           issued,
    output logic [CNT_W-1:0]           waiting,
    output logic [N_TEL-1:0]           pending,
    output logic                       call_valid,
    output logic [$clog2(N_TEL)-1:0]   call_teller,
    output logic [CNT_W-1:0]           call_num,
    output logic [N_TEL*CNT_W-1:0]     served,
    output logic                       busy
);

    localparam int TW = $clog2(N_TEL);

    typedef enum logic [1:0] {IDLE, ANNOUNCE, GAP_WAIT} stateType;

    stateType         state;
    logic [CNT_W-1:0] called;
    logic [N_TEL-1:0] callReqPrev;
    logic [TW-1:0]    rrPtr;
    logic [3:0]       gapCnt;

    logic [TW-1:0]    grantIdx;
    logic [TW-1:0]    searchIdx;
    logic             grantHit;
    logic             grantNow;
    logic             takeOk;
    logic [N_TEL-1:0] pendingNext;

    assign waiting  = issued - called;
    assign busy     = (state != IDLE);
    assign takeOk   = take_num && (waiting != '1);
    assign grantNow = (state == IDLE) && grantHit && (waiting != '0);

    // First pending teller after the last one served, wrapping around.
    always_comb begin
        grantIdx  = '0;
        searchIdx = '0;
        grantHit  = 1'b0;
        for (int k = 1; k <= N_TEL; k++) begin
            searchIdx = TW'((int'(rrPtr) + k) % N_TEL);
            if (!grantHit && pending[searchIdx]) begin
                grantHit = 1'b1;
                grantIdx = searchIdx;
            end
        end
    end

    // A grant clears its own bit even if that button is re-pressed the same cycle.
    always_comb begin
        pendingNext = (pending | (call_req & ~callReqPrev)) & teller_open;
        if (grantNow) pendingNext[grantIdx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            issued      <= '0;
            called      <= '0;
            pending     <= '0;
            callReqPrev <= '0;
            rrPtr       <= TW'(N_TEL - 1);
            gapCnt      <= '0;
            call_valid  <= 1'b0;
            call_teller <= '0;
            call_num    <= '0;
            served      <= '0;
        end else begin
            callReqPrev <= call_req;
            if (!bank_open) begin
                state      <= IDLE;
                issued     <= '0;
                called     <= '0;
                pending    <= '0;
                rrPtr      <= '0;
                gapCnt     <= '0;
                call_valid <= 1'b0;
            end else begin
                pending <= pendingNext;
                if (takeOk) issued <= issued + 1'b1;
                case (state)
                    IDLE: begin
                        if (grantNow) begin
                            call_teller <= grantIdx;
                            call_num    <= called + 1'b1;
                            served[int'(grantIdx)*CNT_W +: CNT_W] <= called + 1'b1;
                            called      <= called + 1'b1;
                            rrPtr       <= grantIdx;
                            call_valid  <= 1'b1;
                            state       <= ANNOUNCE;
                        end
                    end
                    ANNOUNCE: begin
                        if (ann_ready) begin
                            call_valid <= 1'b0;
                            gapCnt     <= 4'(GAP - 1);
                            state      <= GAP_WAIT;
                        end
                    end
                    GAP_WAIT: begin
                        if (gapCnt == '0) state <= IDLE;
                        else gapCnt <= gapCnt - 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_teller_call_scheduler.sv
// Bench for teller_call_scheduler: directed scenarios plus random traffic,
// every cycle compared against a queue-level reference model.
module tb_teller_call_scheduler;

    localparam int N = 4;
    localparam int W = 8;
    localparam int G = 3;
    localparam int M = 1 << W;

    logic           clk = 1'b0;
    logic           rst, bank_open, take_num, ann_ready;
    logic [N-1:0]   teller_open, call_req;
    logic [W-1:0]   issued, waiting, call_num;
    logic [N-1:0]   pending;
    logic           call_valid, busy;
    logic [1:0]     call_teller;
    logic [N*W-1:0] served;

    teller_call_scheduler #(.N_TEL(N), .CNT_W(W), .GAP(G)) dut (
        .clk(clk), .rst(rst), .bank_open(bank_open), .teller_open(teller_open),
        .call_req(call_req), .take_num(take_num), .ann_ready(ann_ready),
        .issued(issued), .waiting(waiting), .pending(pending),
        .call_valid(call_valid), .call_teller(call_teller), .call_num(call_num),
        .served(served), .busy(busy)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatched = 0;
    int cycleNo = 0;

    // Reference model: ticket counts, button latches, announce-in-flight flag
    // and remaining quiet cycles.
    int           mIssued, mCalled, mRr, mCool, mTeller, mNum;
    bit           mAnn, mValid;
    logic [N-1:0] mPending, mPrev;
    int           mServed[N];

    function automatic int modW(int v);
        return ((v % M) + M) % M;
    endfunction

    task automatic checkVal(string tag, logic [63:0] obs, logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cycleNo, obs, exp);
        end
    endtask

    task automatic modelStep();
        int           avail;
        int           g;
        logic [N-1:0] nextPend;
        if (rst) begin
            mIssued = 0; mCalled = 0; mRr = N - 1; mCool = 0; mTeller = 0; mNum = 0;
            mAnn = 0; mValid = 0; mPending = '0; mPrev = '0;
            for (int i = 0; i < N; i++) mServed[i] = 0;
        end else begin
            if (!bank_open) begin
                mIssued = 0; mCalled = 0; mPending = '0; mRr = 0;
                mAnn = 0; mValid = 0; mCool = 0;
            end else begin
                avail = modW(mIssued - mCalled);
                g = -1;
                if (!mAnn && mCool == 0 && mPending != '0 && avail != 0)
                    for (int k = 1; k <= N; k++)
                        if (g < 0 && mPending[(mRr + k) % N]) g = (mRr + k) % N;
                nextPend = (mPending | (call_req & ~mPrev)) & teller_open;
                if (take_num && avail != M - 1) mIssued = modW(mIssued + 1);
                if (g >= 0) begin
                    nextPend[g] = 1'b0;
                    mCalled = modW(mCalled + 1);
                    mNum = mCalled;
                    mTeller = g;
                    mServed[g] = mCalled;
                    mRr = g;
                    mAnn = 1;
                    mValid = 1;
                end else if (mAnn) begin
                    if (ann_ready) begin
                        mAnn = 0; mValid = 0; mCool = G;
                    end
                end else if (mCool > 0) begin
                    mCool--;
                end
                mPending = nextPend;
            end
            mPrev = call_req;
        end
    endtask

    task automatic compareAll();
        checkVal("issued", issued, mIssued);
        checkVal("waiting", waiting, modW(mIssued - mCalled));
        checkVal("pending", pending, mPending);
        checkVal("call_valid", call_valid, mValid);
        checkVal("call_teller", call_teller, mTeller);
        checkVal("call_num", call_num, mNum);
        checkVal("busy", busy, (mAnn || mCool > 0));
        for (int i = 0; i < N; i++) checkVal("served", served[i*W +: W], mServed[i]);
    endtask

    task automatic tick();
        modelStep();
        @(negedge clk);
        cycleNo++;
        compareAll();
    endtask

    task automatic doReset();
        rst = 1; bank_open = 1; teller_open = '1; call_req = '0; take_num = 0; ann_ready = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic waitValid(string tag, int budget);
        int c = 0;
        while (!call_valid && c < budget) begin
            tick();
            c++;
        end
        if (!call_valid) checkVal(tag, call_valid, 1);
    endtask

    int  rises, lastRise;
    bit  prevValid;

    initial begin
        rst = 1; bank_open = 1; teller_open = '1; call_req = '0; take_num = 0; ann_ready = 1;

        // first call after three tickets
        doReset();
        checkVal("rst_rr_issued", issued, 0);
        take_num = 1; repeat (3) tick();
        take_num = 0; call_req = 4'b0100; tick();
        checkVal("r40_issued", issued, 3);
        call_req = '0; tick();
        checkVal("r40_valid", call_valid, 1);
        checkVal("r40_teller", call_teller, 2);
        checkVal("r40_num", call_num, 1);
        checkVal("r40_served2", served[2*W +: W], 1);
        checkVal("r40_waiting", waiting, 2);

        // all four buttons together: round-robin order and spacing
        doReset();
        take_num = 1; repeat (4) tick();
        take_num = 0; call_req = '1;
        rises = 0; lastRise = 0; prevValid = 0;
        for (int c = 0; c < 60 && rises < 4; c++) begin
            tick();
            if (call_valid && !prevValid) begin
                checkVal("r41_teller", call_teller, rises);
                checkVal("r41_num", call_num, rises + 1);
                if (rises > 0) checkVal("r41_spacing", cycleNo - lastRise, G + 2);
                lastRise = cycleNo;
                rises++;
            end
            prevValid = call_valid;
        end
        checkVal("r41_count", rises, 4);
        call_req = '0;

        // announcer stalls for ten cycles
        doReset();
        take_num = 1; tick();
        take_num = 0; call_req = 4'b0010; ann_ready = 0; tick();
        call_req = '0;
        waitValid("r42_timeout", 10);
        for (int c = 0; c < 10; c++) begin
            tick();
            checkVal("r42_hold_valid", call_valid, 1);
            checkVal("r42_hold_teller", call_teller, 1);
            checkVal("r42_hold_num", call_num, 1);
        end
        ann_ready = 1; tick();
        checkVal("r42_done_valid", call_valid, 0);
        checkVal("r42_waiting", waiting, 0);
        checkVal("r42_busy", busy, 1);

        // pending teller with an empty queue, then one ticket
        doReset();
        call_req = 4'b1000; tick();
        call_req = '0; repeat (3) tick();
        checkVal("r43_nogrant_empty", call_valid, 0);
        checkVal("r43_pending", pending, 4'b1000);
        take_num = 1; tick();
        take_num = 0;
        checkVal("r43_issued", issued, 1);
        checkVal("r43_nogrant_same", busy, 0);
        tick();
        checkVal("r43_valid", call_valid, 1);
        checkVal("r43_teller", call_teller, 3);
        checkVal("r43_num", call_num, 1);

        // full queue and issued wrap
        doReset();
        take_num = 1; repeat (256) tick();
        take_num = 0;
        checkVal("r44_issued_full", issued, 255);
        checkVal("r44_waiting_full", waiting, 255);
        take_num = 1; tick();
        take_num = 0;
        checkVal("r44_issued_held", issued, 255);
        call_req = 4'b0001; tick();
        call_req = '0;
        waitValid("r44_timeout", 10);
        tick();
        take_num = 1; tick();
        take_num = 0;
        checkVal("r44_issued_wrap", issued, 0);
        checkVal("r44_waiting_wrap", waiting, 255);

        // bank closes mid-announce, then reset mid-gap
        doReset();
        take_num = 1; repeat (2) tick();
        take_num = 0; ann_ready = 0; call_req = 4'b0001; tick();
        call_req = '0;
        waitValid("r45_timeout_a", 10);
        bank_open = 0; tick();
        checkVal("r45_drop_valid", call_valid, 0);
        checkVal("r45_drop_busy", busy, 0);
        checkVal("r45_drop_issued", issued, 0);
        checkVal("r45_served_kept", served[0 +: W], 1);
        bank_open = 1; tick();
        take_num = 1; tick();
        take_num = 0; ann_ready = 1; call_req = 4'b0001; tick();
        call_req = '0;
        waitValid("r45_timeout_b", 10);
        tick();
        checkVal("r45_in_gap", busy, 1);
        rst = 1; tick();
        rst = 0;
        checkVal("r45_rst_served", served, 0);
        checkVal("r45_rst_busy", busy, 0);
        checkVal("r45_rst_valid", call_valid, 0);
        checkVal("r45_rst_issued", issued, 0);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 1499) == 0);
            bank_open = ($urandom_range(0, 999) != 0);
            for (int i = 0; i < N; i++) teller_open[i] = ($urandom_range(0, 19) != 0);
            call_req = N'($urandom);
            take_num = ($urandom_range(0, 2) != 0);
            ann_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/teller_call_scheduler.md
TELLER_CALL_SCHEDULER -- requirements
Module: teller_call_scheduler

Interface
REQ-001 SHALL have parameter N_TEL, default 4, number of teller counters.
REQ-002 SHALL have parameter CNT_W, default 8, width of queue numbers.
REQ-003 SHALL have parameter GAP, default 3, idle cycles after each announced call; range 1..15.
REQ-004 SHALL have one clock; reset is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 SHALL have bank_open input 1, bank open level.
REQ-006 SHALL have teller_open input N_TEL, per-counter open level.
REQ-007 SHALL have call_req input N_TEL, per-teller call button level.
REQ-008 SHALL have take_num input 1, customer ticket request, one pulse per ticket.
REQ-009 SHALL have ann_ready input 1, display/announcer accepts the call.
REQ-010 SHALL have issued output CNT_W, last ticket number handed out.
REQ-011 SHALL have waiting output CNT_W, issued minus called, modulo 2^CNT_W.
REQ-012 SHALL have pending output N_TEL, latched call requests.
REQ-013 SHALL have call_valid output 1, an announce is offered.
REQ-014 SHALL have call_teller output clog2(N_TEL), granted teller index.
REQ-015 SHALL have call_num output CNT_W, number being announced.
REQ-016 SHALL have served output N_TEL*CNT_W, last number called per teller; teller i occupies bits [i*CNT_W +: CNT_W].
REQ-017 SHALL have busy output 1, high when the FSM is not in IDLE.

Function
REQ-018 SHALL set pending[i] on a call_req[i] rising edge (a 0 in the previous cycle, a 1 in this one) while teller_open[i]=1 and bank_open=1; a held button SHALL set pending only once.
REQ-019 SHALL clear pending[i] when teller i is granted, or in any cycle where teller_open[i]=0.
REQ-020 SHALL increment issued on take_num=1 while bank_open=1 and waiting != 2^CNT_W-1; when waiting is full, take_num SHALL be ignored.
REQ-021 SHALL keep a registered counter called; waiting = issued - called.
REQ-022 SHALL use FSM states IDLE, ANNOUNCE and GAP_WAIT.
REQ-023 SHALL grant in IDLE when pending != 0 and registered waiting != 0.
REQ-024 On a grant SHALL pick round-robin: the first set pending bit searching from rr_ptr+1 upward, wrapping modulo N_TEL.
REQ-025 In the grant cycle SHALL load call_teller=i, call_num=called+1, served[i]=called+1, increment called, set rr_ptr=i and clear pending[i]; next state ANNOUNCE.
REQ-026 In ANNOUNCE SHALL hold call_valid=1 with call_teller and call_num stable until ann_ready=1.
REQ-027 The transfer SHALL occur in the cycle where call_valid=1 and ann_ready=1; next state GAP_WAIT and call_valid=0.
REQ-028 In GAP_WAIT SHALL count GAP cycles, then go to IDLE; no grant before the next IDLE cycle.
REQ-029 Minimum spacing between call_valid rising edges SHALL be GAP+2 cycles with ann_ready tied high.
REQ-030 take_num together with a grant in the same cycle SHALL apply both; waiting ends unchanged.
REQ-031 take_num while waiting=0 and pending!=0 SHALL make the grant occur in the following cycle, never the same cycle.
REQ-032 Teller i closing during ANNOUNCE/GAP_WAIT SHALL not abort the announce; served[i] SHALL be retained.
REQ-033 Counters SHALL wrap modulo 2^CNT_W; call_num after 2^CNT_W-1 SHALL be 0.
REQ-034 While bank_open=0 SHALL hold issued, called, pending and rr_ptr at 0 and the FSM in IDLE with call_valid=0; served SHALL be retained.
REQ-035 An announce in progress when bank_open falls SHALL be dropped.
REQ-036 SHALL assert busy whenever the FSM is not in IDLE.

Reset
REQ-037 While rst=1 at a clk edge SHALL clear issued, called, waiting, pending, served, call_num, call_teller, call_valid, busy and the gap counter, set rr_ptr=N_TEL-1 and set the FSM to IDLE.
REQ-038 rst SHALL take priority over every other input, including mid-ANNOUNCE.
REQ-039 The first cycle after rst deasserts SHALL treat the previous call_req as 0.

Verification
REQ-040 Bank open, 3 take_num pulses, call_req[2] rising, ann_ready=1 -> issued=3; call_valid one cycle later with call_teller=2, call_num=1; served[2]=1; waiting=2.
REQ-041 From rst, waiting=4, call_req[0..3] all rising in the same cycle, ann_ready=1 -> grants to 0,1,2,3 in order, call_num 1..4, each spaced GAP+2 cycles.
REQ-042 Grant to teller 1 with ann_ready=0 for 10 cycles -> call_valid, call_teller=1 and call_num stable all 10 cycles; one transfer on ann_ready=1; called advanced once.
REQ-043 waiting=0 and pending[3]=1, then take_num -> grant in the cycle after issued increments; call_num=issued.
REQ-044 issued=255, called=0, take_num -> issued stays 255 and waiting stays 255; after one call, take_num -> issued=0 and waiting=255.
REQ-045 bank_open falls during ANNOUNCE, then rst mid-GAP_WAIT -> call_valid=0 next cycle, counters cleared, served cleared only by rst, FSM in IDLE.
